// File: rtl/io_map_pkg.sv
// io_map_pkg: I/O port map, peripheral target encoding and bridge state type
package io_map_pkg;
  typedef enum logic [3:0] {
    LEDS, SDRAM_CFG, UART, SPI, IRQ_CTL, BIOS_CTL, TIMER, PIC, VGA, PS2
  } io_target_t;
  localparam int NUM_IO_TARGETS = 10;
  localparam logic [15:0] PORT_LEDS      = 16'hFFFE;
  localparam logic [15:0] PORT_SDRAM_CFG = 16'hFFFC;
  localparam logic [15:0] PORT_UART      = 16'hFFFA;
  localparam logic [15:0] PORT_SPI0      = 16'hFFF0;
  localparam logic [15:0] PORT_SPI1      = 16'hFFF2;
  localparam logic [15:0] PORT_IRQ_CTL   = 16'hFFF6;
  localparam logic [15:0] PORT_BIOS_CTL  = 16'hFFEC;
  localparam logic [15:0] PORT_TIMER0    = 16'h0040;
  localparam logic [15:0] PORT_TIMER1    = 16'h0042;
  localparam logic [15:0] PORT_PIC       = 16'h0020;
  localparam logic [15:0] PORT_VGA_BASE  = 16'h03D0;
  localparam logic [15:0] PORT_PS2       = 16'h0060;
  localparam logic [15:0] IO_TIMEOUT_DATA = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, WAIT, DFLT, DONE} bridge_state_t;
endpackage

// File: rtl/io_addr_decode.sv
// io_addr_decode: maps an I/O port address to its peripheral target
module io_addr_decode
  import io_map_pkg::*;
#(
  parameter bit HAS_VGA = 1'b1,
  parameter bit HAS_PS2 = 1'b1
) (
  input  logic [15:1] addr,
  output logic        hit,
  output io_target_t  target
);
  logic [15:0] port;
  assign port = {addr, 1'b0};
  always_comb begin
    hit = 1'b1;
    target = LEDS;
    if (port == PORT_LEDS) target = LEDS;
    else if (port == PORT_SDRAM_CFG) target = SDRAM_CFG;
    else if (port == PORT_UART) target = UART;
    else if (port == PORT_SPI0 || port == PORT_SPI1) target = SPI;
    else if (port == PORT_IRQ_CTL) target = IRQ_CTL;
    else if (port == PORT_BIOS_CTL) target = BIOS_CTL;
    else if (port == PORT_TIMER0 || port == PORT_TIMER1) target = TIMER;
    else if (port == PORT_PIC) target = PIC;
    else if (HAS_VGA && port[15:4] == PORT_VGA_BASE[15:4]) target = VGA;
    else if (HAS_PS2 && port == PORT_PS2) target = PS2;
    else hit = 1'b0;
  end
endmodule

// File: rtl/io_port_bridge.sv
// io_port_bridge: registered Core-to-peripheral I/O bridge with default responder and timeout
module io_port_bridge
  import io_map_pkg::*;
#(
  parameter bit          HAS_VGA        = 1'b1,
  parameter bit          HAS_PS2        = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_in_n,
  input  logic                      data_m_access,
  input  logic                      d_io,
  input  logic [19:1]               data_m_addr,
  input  logic [15:0]               data_m_data_in,
  input  logic                      data_m_wr_en,
  input  logic [1:0]                data_m_bytesel,
  output logic                      data_m_ack,
  output logic [15:0]               data_m_data_out,
  output logic [NUM_IO_TARGETS-1:0] io_cs,
  output logic [19:1]               io_addr,
  output logic [15:0]               io_wdata,
  output logic                      io_wr_en,
  output logic [1:0]                io_bytesel,
  input  logic                      io_ack,
  input  logic [15:0]               io_rdata,
  output logic                      timeout_flag,
  output logic [15:0]               timeout_addr,
  input  logic                      timeout_clr
);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  bridge_state_t state;
  logic [15:0]   cnt;
  logic          hit;
  io_target_t    tgt;
  io_addr_decode #(.HAS_VGA(HAS_VGA), .HAS_PS2(HAS_PS2)) u_dec (
    .addr(data_m_addr[15:1]),
    .hit(hit),
    .target(tgt)
  );
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state <= IDLE;
      cnt <= '0;
      data_m_ack <= 1'b0;
      data_m_data_out <= '0;
      io_cs <= '0;
      io_addr <= '0;
      io_wdata <= '0;
      io_wr_en <= 1'b0;
      io_bytesel <= '0;
      timeout_flag <= 1'b0;
      timeout_addr <= '0;
    end else begin
      data_m_ack <= 1'b0;
      data_m_data_out <= '0;
      if (timeout_clr) timeout_flag <= 1'b0;
      case (state)
        IDLE: if (data_m_access && d_io) begin
          io_addr <= data_m_addr;
          io_wdata <= data_m_data_in;
          io_wr_en <= data_m_wr_en;
          io_bytesel <= data_m_bytesel;
          io_cs <= hit ? (NUM_IO_TARGETS'(1) << tgt) : '0;
          cnt <= '0;
          state <= hit ? WAIT : DFLT;
        end
        WAIT: if (!data_m_access) begin
          io_cs <= '0;
          state <= IDLE;
        end else if (io_ack) begin
          io_cs <= '0;
          data_m_ack <= 1'b1;
          data_m_data_out <= io_wr_en ? 16'h0000 : io_rdata;
          state <= DONE;
        end else if (cnt == TMO_LAST) begin
          // a new timeout overrides a same-cycle clear; only the first address is kept
          io_cs <= '0;
          data_m_ack <= 1'b1;
          data_m_data_out <= IO_TIMEOUT_DATA;
          timeout_flag <= 1'b1;
          if (!timeout_flag) timeout_addr <= {io_addr[15:1], 1'b0};
          state <= DONE;
        end else begin
          cnt <= cnt + 16'd1;
        end
        DFLT: if (!data_m_access) begin
          state <= IDLE;
        end else begin
          data_m_ack <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_port_bridge.sv
// tb_io_port_bridge: directed-vector bench for io_port_bridge (HAS_PS2=0, TIMEOUT_CYCLES=8)
module tb_io_port_bridge;
  logic        clk;
  logic        rst_in_n;
  logic        data_m_access;
  logic        d_io;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_in;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic        data_m_ack;
  logic [15:0] data_m_data_out;
  logic [9:0]  io_cs;
  logic [19:1] io_addr;
  logic [15:0] io_wdata;
  logic        io_wr_en;
  logic [1:0]  io_bytesel;
  logic        io_ack;
  logic [15:0] io_rdata;
  logic        timeout_flag;
  logic [15:0] timeout_addr;
  logic        timeout_clr;
  int nvec = 0;
  int nerr = 0;
  io_port_bridge #(.HAS_VGA(1'b1), .HAS_PS2(1'b0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rst_in_n(rst_in_n),
    .data_m_access(data_m_access),
    .d_io(d_io),
    .data_m_addr(data_m_addr),
    .data_m_data_in(data_m_data_in),
    .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel),
    .data_m_ack(data_m_ack),
    .data_m_data_out(data_m_data_out),
    .io_cs(io_cs),
    .io_addr(io_addr),
    .io_wdata(io_wdata),
    .io_wr_en(io_wr_en),
    .io_bytesel(io_bytesel),
    .io_ack(io_ack),
    .io_rdata(io_rdata),
    .timeout_flag(timeout_flag),
    .timeout_addr(timeout_addr),
    .timeout_clr(timeout_clr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [15:0] port, input logic wr, input logic [15:0] wd, input logic [1:0] bs);
    data_m_access = 1'b1;
    d_io = 1'b1;
    data_m_addr = {4'b0, port[15:1]};
    data_m_wr_en = wr;
    data_m_data_in = wd;
    data_m_bytesel = bs;
  endtask
  // idx < 0 means the port must be answered by the bridge itself
  task automatic xfer(input string tag, input logic [15:0] port, input logic wr, input logic [15:0] wd,
                      input logic [1:0] bs, input int idx, input logic [15:0] rd, input logic [15:0] exp);
    logic [31:0] cs;
    cs = (idx < 0) ? 32'd0 : (32'd1 << idx);
    drive(port, wr, wd, bs);
    step;
    check({tag, ".c1_cs"}, io_cs, cs);
    check({tag, ".c1_ack"}, data_m_ack, 0);
    check({tag, ".addr"}, io_addr, {4'b0, port[15:1]});
    check({tag, ".wr"}, io_wr_en, wr);
    check({tag, ".wdata"}, io_wdata, wd);
    check({tag, ".bsel"}, io_bytesel, bs);
    if (idx >= 0) begin
      step;
      check({tag, ".c2_cs"}, io_cs, cs);
      check({tag, ".c2_ack"}, data_m_ack, 0);
      io_ack = 1'b1;
      io_rdata = rd;
    end
    step;
    io_ack = 1'b0;
    io_rdata = 16'h0;
    check({tag, ".ack"}, data_m_ack, 1);
    check({tag, ".data"}, data_m_data_out, exp);
    check({tag, ".cs_off"}, io_cs, 0);
    data_m_access = 1'b0;
    step;
    check({tag, ".ack_off"}, data_m_ack, 0);
    check({tag, ".data_off"}, data_m_data_out, 0);
  endtask
  task automatic tmo(input string tag, input logic [15:0] port, input int idx, input logic ack_last,
                     input logic clr_last, input logic [15:0] exp, input logic eflag, input logic [15:0] etaddr);
    drive(port, 1'b0, 16'h0, 2'b11);
    for (int i = 1; i <= 8; i++) begin
      step;
      check({tag, ".cs"}, io_cs, 32'd1 << idx);
      check({tag, ".noack"}, data_m_ack, 0);
      if (i == 8) begin
        io_ack = ack_last;
        io_rdata = 16'h5A5A;
        timeout_clr = clr_last;
      end
    end
    step;
    io_ack = 1'b0;
    io_rdata = 16'h0;
    timeout_clr = 1'b0;
    check({tag, ".ack"}, data_m_ack, 1);
    check({tag, ".data"}, data_m_data_out, exp);
    check({tag, ".cs_off"}, io_cs, 0);
    check({tag, ".flag"}, timeout_flag, eflag);
    check({tag, ".taddr"}, timeout_addr, etaddr);
    data_m_access = 1'b0;
    step;
    check({tag, ".ack_off"}, data_m_ack, 0);
  endtask
  initial begin
    rst_in_n = 1'b0;
    data_m_access = 1'b0;
    d_io = 1'b0;
    data_m_addr = '0;
    data_m_data_in = '0;
    data_m_wr_en = 1'b0;
    data_m_bytesel = '0;
    io_ack = 1'b0;
    io_rdata = '0;
    timeout_clr = 1'b0;
    repeat (2) step;
    check("rst.ack", data_m_ack, 0);
    check("rst.data", data_m_data_out, 0);
    check("rst.cs", io_cs, 0);
    check("rst.flag", timeout_flag, 0);
    check("rst.taddr", timeout_addr, 0);
    rst_in_n = 1'b1;
    step;
    xfer("uart", 16'hFFFA, 1'b0, 16'h0000, 2'b11, 2, 16'h00A5, 16'h00A5);
    xfer("timer_wr", 16'h0042, 1'b1, 16'h1234, 2'b01, 6, 16'hBEEF, 16'h0000);
    xfer("unmapped", 16'h0300, 1'b0, 16'h0000, 2'b11, -1, 16'h0000, 16'h0000);
    xfer("ps2_off", 16'h0060, 1'b0, 16'h0000, 2'b11, -1, 16'h0000, 16'h0000);
    xfer("vga", 16'h03D4, 1'b0, 16'h0000, 2'b10, 8, 16'h1357, 16'h1357);
    // memory cycles must leave the bridge untouched
    drive(16'hFFFA, 1'b1, 16'hAAAA, 2'b11);
    d_io = 1'b0;
    step;
    check("mem.cs", io_cs, 0);
    check("mem.addr", io_addr, {4'b0, 15'h01EA});
    step;
    check("mem.ack", data_m_ack, 0);
    data_m_access = 1'b0;
    step;
    drive(16'hFFFC, 1'b0, 16'h0, 2'b11);
    step;
    check("abort.cs", io_cs, 10'b0000000010);
    data_m_access = 1'b0;
    step;
    check("abort.cs_off", io_cs, 0);
    check("abort.ack", data_m_ack, 0);
    step;
    check("abort.ack2", data_m_ack, 0);
    check("abort.flag", timeout_flag, 0);
    tmo("tack", 16'hFFF0, 3, 1'b1, 1'b0, 16'h5A5A, 1'b0, 16'h0000);
    tmo("t20", 16'h0020, 7, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'h0020);
    tmo("tf6", 16'hFFF6, 4, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0020);
    drive(16'hFFFE, 1'b0, 16'h0, 2'b11);
    step;
    check("arst.cs_pre", io_cs, 10'b0000000001);
    #2 rst_in_n = 1'b0;
    #1;
    check("arst.cs", io_cs, 0);
    check("arst.addr", io_addr, 0);
    check("arst.flag", timeout_flag, 0);
    check("arst.taddr", timeout_addr, 0);
    check("arst.ack", data_m_ack, 0);
    data_m_access = 1'b0;
    step;
    rst_in_n = 1'b1;
    step;
    tmo("t20b", 16'h0020, 7, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'h0020);
    timeout_clr = 1'b1;
    step;
    timeout_clr = 1'b0;
    check("clr.flag", timeout_flag, 0);
    check("clr.taddr", timeout_addr, 16'h0020);
    xfer("leds", 16'hFFFE, 1'b0, 16'h0000, 2'b11, 0, 16'h1111, 16'h1111);
    xfer("bios", 16'hFFEC, 1'b0, 16'h0000, 2'b11, 5, 16'h2222, 16'h2222);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
